// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N-way arbitrated mux.
// Arbitration mode enum and select-width function.
package arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority or round-robin with a wrap pointer.
// Ports: clk, rst_n, req[N], advance -> grant[N], grant_idx[SELW].
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  localparam int CW   = SELW + 1;
  localparam int PADN = 1 << SELW;
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_base;
  logic [PADN-1:0] w_req_pad;
  logic [CW-1:0]   w_cand;
  logic [SELW-1:0] w_idx;
  logic            w_hit;

  // Fixed priority is a round-robin search that always starts at 0.
  assign w_base    = (MODE == ARB_RR) ? r_ptr : '0;
  assign w_req_pad = PADN'(req);

  // Search base, base+1, ... with an explicit modulo-N wrap so that
  // non-power-of-two N never lands on a nonexistent channel.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, w_base} + CW'(k);
      if (w_cand >= CW'(N))
        w_cand = w_cand - CW'(N);
      if (!w_hit && w_req_pad[w_cand[SELW-1:0]]) begin
        w_hit = 1'b1;
        w_idx = w_cand[SELW-1:0];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_oh
    assign grant[i] = w_hit && (w_idx == SELW'(i));
  end

  assign grant_idx = w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (w_idx == LAST) ? '0 : w_idx + SELW'(1);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-way valid/ready mux with arbitration and one registered output stage.
// Ports: in_valid/in_data/in_ready per channel; out_valid/out_data/out_sel/out_ready.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SELW  = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [WIDTH-1:0] in_data [N],
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;

  logic             w_load;
  logic             w_any;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_data;

  // Register is free when empty or being drained this very cycle.
  assign w_load = !r_valid || out_ready;
  assign w_any  = |w_grant;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (w_load && w_any),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++)
      w_data = w_data | (in_data[i] & {WIDTH{w_grant[i]}});
  end

  // rst_n gate keeps producers from seeing an accept during reset.
  assign in_ready = w_grant & {N{w_load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= w_data;
        r_sel  <= w_idx;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
